// File: rtl/alu_pipe_core.sv
// Three-stage (D/E/W) RV32I register/immediate ALU pipeline with valid/ready streams,
// selectable E/W operand forwarding or RAW interlock, back-pressure and a retire counter.
module alu_pipe_core #(
  parameter int XLEN       = 32,
  parameter bit FORWARD_EN = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [4:0]       out_rd,
  output logic [CNT_W-1:0] retired_count
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  logic            d_valid_q, d_valid_d;
  logic [31:0]     d_instr_q, d_instr_d;
  logic            e_valid_q, e_valid_d;
  logic [4:0]      e_rd_q, e_rd_d;
  logic [XLEN-1:0] e_a_q, e_a_d;
  logic [XLEN-1:0] e_b_q, e_b_d;
  logic [2:0]      e_f3_q, e_f3_d;
  logic            e_alt_q, e_alt_d;
  logic            w_valid_q, w_valid_d;
  logic [XLEN-1:0] w_data_q, w_data_d;
  logic [4:0]      w_rd_q, w_rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rf_q [32];
  logic [XLEN-1:0] rf_d [32];

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm;
  logic            is_r, is_i, legal, alt;
  logic [XLEN-1:0] src_a, src_b, op_b;
  logic            hz_a, hz_b, hazard_stall;
  logic [XLEN-1:0] e_result;
  logic [SHW-1:0]  shamt;
  logic            adv_w, d_fire, wr_fire, d_issue;

  // Decode of the word held in D; alt selects SUB/SRA/SRAI.
  always_comb begin
    opcode = d_instr_q[6:0];
    rd     = d_instr_q[11:7];
    f3     = d_instr_q[14:12];
    rs1    = d_instr_q[19:15];
    rs2    = d_instr_q[24:20];
    f7     = d_instr_q[31:25];
    imm    = {{(XLEN-12){d_instr_q[31]}}, d_instr_q[31:20]};
    is_r   = (opcode == OP_R);
    is_i   = (opcode == OP_I);
    legal  = 1'b0;
    alt    = 1'b0;
    if (is_r) begin
      if (f7 == 7'b0000000) begin
        legal = 1'b1;
      end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
        legal = 1'b1;
        alt   = 1'b1;
      end
    end else if (is_i) begin
      if (f3 == 3'b001) begin
        legal = (d_instr_q[31:26] == 6'b000000) && (XLEN > 32 || !d_instr_q[25]);
      end else if (f3 == 3'b101) begin
        legal = (d_instr_q[31:26] == 6'b000000 || d_instr_q[31:26] == 6'b010000) &&
                (XLEN > 32 || !d_instr_q[25]);
        alt   = d_instr_q[30];
      end else begin
        legal = 1'b1;
      end
    end
  end

  always_comb begin
    shamt    = e_b_q[SHW-1:0];
    e_result = '0;
    case (e_f3_q)
      3'b000:  e_result = e_alt_q ? (e_a_q - e_b_q) : (e_a_q + e_b_q);
      3'b001:  e_result = e_a_q << shamt;
      3'b010:  e_result = {{(XLEN-1){1'b0}}, ($signed(e_a_q) < $signed(e_b_q))};
      3'b011:  e_result = {{(XLEN-1){1'b0}}, (e_a_q < e_b_q)};
      3'b100:  e_result = e_a_q ^ e_b_q;
      3'b101:  e_result = e_alt_q ? $unsigned($signed(e_a_q) >>> shamt) : (e_a_q >> shamt);
      3'b110:  e_result = e_a_q | e_b_q;
      default: e_result = e_a_q & e_b_q;
    endcase
  end

  // Operand fetch: the E result is newer than W, which is newer than the register file.
  always_comb begin
    src_a = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    src_b = (rs2 == 5'd0) ? '0 : rf_q[rs2];
    if (FORWARD_EN && rs1 != 5'd0) begin
      if (e_valid_q && e_rd_q == rs1)      src_a = e_result;
      else if (w_valid_q && w_rd_q == rs1) src_a = w_data_q;
    end
    if (FORWARD_EN && rs2 != 5'd0) begin
      if (e_valid_q && e_rd_q == rs2)      src_b = e_result;
      else if (w_valid_q && w_rd_q == rs2) src_b = w_data_q;
    end
    op_b = is_r ? src_b : imm;
    hz_a = (rs1 != 5'd0) && ((e_valid_q && e_rd_q == rs1) || (w_valid_q && w_rd_q == rs1));
    hz_b = is_r && (rs2 != 5'd0) &&
           ((e_valid_q && e_rd_q == rs2) || (w_valid_q && w_rd_q == rs2));
    hazard_stall = !FORWARD_EN && d_valid_q && legal && (hz_a || hz_b);
  end

  // Illegal words leave D like any other instruction but enter E as a bubble.
  always_comb begin
    adv_w    = !w_valid_q || out_ready;
    d_fire   = adv_w && !hazard_stall;
    in_ready = !d_valid_q || d_fire;
    wr_fire  = w_valid_q && out_ready;
    d_issue  = d_valid_q && legal && !hazard_stall;

    d_valid_d = d_valid_q;
    d_instr_d = d_instr_q;
    e_valid_d = e_valid_q;
    e_rd_d    = e_rd_q;
    e_a_d     = e_a_q;
    e_b_d     = e_b_q;
    e_f3_d    = e_f3_q;
    e_alt_d   = e_alt_q;
    w_valid_d = w_valid_q;
    w_data_d  = w_data_q;
    w_rd_d    = w_rd_q;
    cnt_d     = cnt_q;
    rf_d      = rf_q;

    if (in_valid && in_ready) begin
      d_valid_d = 1'b1;
      d_instr_d = in_instr;
    end else if (d_fire) begin
      d_valid_d = 1'b0;
    end

    if (adv_w) begin
      e_valid_d = d_issue;
      if (d_issue) begin
        e_rd_d  = rd;
        e_a_d   = src_a;
        e_b_d   = op_b;
        e_f3_d  = f3;
        e_alt_d = alt;
      end
      w_valid_d = e_valid_q;
      if (e_valid_q) begin
        w_data_d = e_result;
        w_rd_d   = e_rd_q;
      end
    end

    if (wr_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (w_rd_q != 5'd0) rf_d[w_rd_q] = w_data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid_q <= 1'b0;
      d_instr_q <= '0;
      e_valid_q <= 1'b0;
      e_rd_q    <= '0;
      e_a_q     <= '0;
      e_b_q     <= '0;
      e_f3_q    <= '0;
      e_alt_q   <= 1'b0;
      w_valid_q <= 1'b0;
      w_data_q  <= '0;
      w_rd_q    <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      d_valid_q <= d_valid_d;
      d_instr_q <= d_instr_d;
      e_valid_q <= e_valid_d;
      e_rd_q    <= e_rd_d;
      e_a_q     <= e_a_d;
      e_b_q     <= e_b_d;
      e_f3_q    <= e_f3_d;
      e_alt_q   <= e_alt_d;
      w_valid_q <= w_valid_d;
      w_data_q  <= w_data_d;
      w_rd_q    <= w_rd_d;
      cnt_q     <= cnt_d;
      rf_q      <= rf_d;
    end
  end

  assign out_valid     = w_valid_q;
  assign out_data      = w_data_q;
  assign out_rd        = w_rd_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_alu_pipe_core.sv
// Scoreboard bench for alu_pipe_core: a forwarding core, an interlocking core and a
// 64-bit core with a 2-bit retire counter, each exercised by its own directed scenarios.
module tb_alu_pipe_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv   [3];
  logic [31:0] ii   [3];
  logic        ordy [3];
  logic        irdy [3];
  logic        ov   [3];
  logic [4:0]  ord  [3];
  logic [31:0] od_a, od_b;
  logic [63:0] od_c;
  logic [31:0] rc_a, rc_b;
  logic [1:0]  rc_c;

  int tests = 0;
  int fails = 0;
  logic [70:0] sb [$];
  logic [70:0] sb_e;

  always #5 clk = ~clk;

  alu_pipe_core #(.XLEN(32), .FORWARD_EN(1'b1), .CNT_W(32)) u_fwd (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .in_instr(ii[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od_a), .out_rd(ord[0]),
    .retired_count(rc_a));

  alu_pipe_core #(.XLEN(32), .FORWARD_EN(1'b0), .CNT_W(32)) u_ilk (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .in_instr(ii[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od_b), .out_rd(ord[1]),
    .retired_count(rc_b));

  alu_pipe_core #(.XLEN(64), .FORWARD_EN(1'b1), .CNT_W(2)) u_x64 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .in_instr(ii[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od_c), .out_rd(ord[2]),
    .retired_count(rc_c));

  function automatic logic [63:0] get_od(input int idx);
    if (idx == 0) return {32'h0, od_a};
    if (idx == 1) return {32'h0, od_b};
    return od_c;
  endfunction

  function automatic logic [31:0] get_rc(input int idx);
    if (idx == 0) return rc_a;
    if (idx == 1) return rc_b;
    return {30'h0, rc_c};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Each handshake seen mid-cycle is matched against the oldest expected result.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ov[i] === 1'b1 && ordy[i] === 1'b1 && rst === 1'b0) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("[TB] FAIL result dut%0d: got rd=%0d data=%h, required no result", i, ord[i], get_od(i));
        end else begin
          sb_e = sb.pop_front();
          if (sb_e[70:69] !== i[1:0] || sb_e[68:64] !== ord[i] || sb_e[63:0] !== get_od(i)) begin
            fails++;
            $display("[TB] FAIL result dut%0d: got rd=%0d data=%h, required dut%0d rd=%0d data=%h",
                     i, ord[i], get_od(i), sb_e[70:69], sb_e[68:64], sb_e[63:0]);
          end
        end
      end
    end
  end

  task automatic send(input int idx, input logic [31:0] instr, input logic [4:0] rd,
                      input logic [63:0] data, input bit counted);
    bit acc;
    acc = 1'b0;
    iv[idx] = 1'b1;
    ii[idx] = instr;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = irdy[idx];
      if (acc && counted) sb.push_back({idx[1:0], rd, data});
      @(posedge clk);
      #1;
    end
    iv[idx] = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept dut%0d: got in_ready=0 for 200 cycles, required 1", idx);
    end
  endtask

  task automatic drain(input int idx);
    for (int n = 0; n < 60 && sb.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain dut%0d: got %0d results outstanding, required 0", idx, sb.size());
    end
    tests++;
    if (ov[idx] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle dut%0d: got out_valid=%b, required 0", idx, ov[idx]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      ii[i] = '0;
      ordy[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      tests += 4;
      if (ov[i] !== 1'b0) begin fails++; $display("[TB] FAIL rst_out_valid dut%0d: got %b, required 0", i, ov[i]); end
      if (ord[i] !== 5'd0) begin fails++; $display("[TB] FAIL rst_out_rd dut%0d: got %0d, required 0", i, ord[i]); end
      if (get_od(i) !== 64'h0) begin fails++; $display("[TB] FAIL rst_out_data dut%0d: got %h, required 0", i, get_od(i)); end
      if (get_rc(i) !== 32'h0) begin fails++; $display("[TB] FAIL rst_count dut%0d: got %0d, required 0", i, get_rc(i)); end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (irdy[i] !== 1'b1) begin fails++; $display("[TB] FAIL rst_in_ready dut%0d: got %b, required 1", i, irdy[i]); end
    end
    @(posedge clk);
    #1;
  endtask

  // Accept happens at the end of cycle 0, so the first result shows in cycle 3.
  task automatic test_forward_chain();
    logic [7:0] pv, pr;
    fork
      begin
        send(0, 32'h00500093, 5'd1, 64'd5, 1'b1);
        send(0, 32'h00108133, 5'd2, 64'd10, 1'b1);
        send(0, 32'h401101B3, 5'd3, 64'd5, 1'b1);
      end
      begin
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          pv[k] = ov[0];
          pr[k] = irdy[0];
        end
      end
    join
    @(posedge clk);
    #1;
    tests += 2;
    if (pv !== 8'b0011_1000) begin fails++; $display("[TB] FAIL fwd_valid_pattern: got %b, required 00111000", pv); end
    if (pr !== 8'hFF) begin fails++; $display("[TB] FAIL fwd_ready_pattern: got %b, required 11111111", pr); end
    drain(0);
    tests++;
    if (rc_a !== 32'd3) begin fails++; $display("[TB] FAIL fwd_count: got %0d, required 3", rc_a); end
  endtask

  task automatic test_interlock_chain();
    logic [10:0] pv, pr;
    fork
      begin
        send(1, 32'h00500093, 5'd1, 64'd5, 1'b1);
        send(1, 32'h00108133, 5'd2, 64'd10, 1'b1);
        send(1, 32'h401101B3, 5'd3, 64'd5, 1'b1);
      end
      begin
        for (int k = 0; k < 11; k++) begin
          @(negedge clk);
          pv[k] = ov[1];
          pr[k] = irdy[1];
        end
      end
    join
    @(posedge clk);
    #1;
    tests += 2;
    if (pv !== 11'h248) begin fails++; $display("[TB] FAIL ilk_valid_pattern: got %b, required 01001001000", pv); end
    if (pr !== 11'h793) begin fails++; $display("[TB] FAIL ilk_ready_pattern: got %b, required 11110010011", pr); end
    drain(1);
    tests++;
    if (rc_b !== 32'd3) begin fails++; $display("[TB] FAIL ilk_count: got %0d, required 3", rc_b); end
  endtask

  task automatic test_back_pressure();
    logic [31:0] base;
    bit seen;
    base = rc_a;
    seen = 1'b0;
    ordy[0] = 1'b0;
    fork
      begin
        send(0, enc_i(12'd5, 5'd0, 3'b000, 5'd1), 5'd1, 64'd5, 1'b1);
        send(0, enc_i(12'd6, 5'd0, 3'b000, 5'd6), 5'd6, 64'd6, 1'b1);
        send(0, enc_i(12'd7, 5'd0, 3'b000, 5'd7), 5'd7, 64'd7, 1'b1);
        send(0, enc_i(12'd8, 5'd0, 3'b000, 5'd8), 5'd8, 64'd8, 1'b1);
      end
      begin
        for (int n = 0; n < 20 && !seen; n++) begin
          @(negedge clk);
          seen = ov[0];
        end
        tests++;
        if (!seen) begin fails++; $display("[TB] FAIL bp_fill: got out_valid=0 for 20 cycles, required 1"); end
        for (int k = 0; k < 4; k++) begin
          if (k > 0) @(negedge clk);
          tests += 4;
          if (ov[0] !== 1'b1) begin fails++; $display("[TB] FAIL bp_hold_valid c%0d: got %b, required 1", k, ov[0]); end
          if (od_a !== 32'd5) begin fails++; $display("[TB] FAIL bp_hold_data c%0d: got %h, required 5", k, od_a); end
          if (ord[0] !== 5'd1) begin fails++; $display("[TB] FAIL bp_hold_rd c%0d: got %0d, required 1", k, ord[0]); end
          if (irdy[0] !== 1'b0) begin fails++; $display("[TB] FAIL bp_in_ready c%0d: got %b, required 0", k, irdy[0]); end
        end
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
      end
    join
    drain(0);
    tests++;
    if (rc_a - base !== 32'd4) begin fails++; $display("[TB] FAIL bp_count: got %0d, required 4", rc_a - base); end
  endtask

  task automatic test_alu_corners();
    logic [31:0] base;
    base = rc_a;
    send(0, enc_i(12'hFFF, 5'd0, 3'b000, 5'd1),         5'd1,  64'hFFFFFFFF, 1'b1);
    send(0, enc_i(12'h404, 5'd1, 3'b101, 5'd2),         5'd2,  64'hFFFFFFFF, 1'b1);
    send(0, enc_i(12'h004, 5'd1, 3'b101, 5'd5),         5'd5,  64'h0FFFFFFF, 1'b1);
    send(0, enc_i(12'hFFF, 5'd0, 3'b011, 5'd3),         5'd3,  64'h1,        1'b1);
    send(0, enc_r(7'h00, 5'd0, 5'd1, 3'b010, 5'd4),     5'd4,  64'h1,        1'b1);
    send(0, enc_i(12'd7, 5'd1, 3'b000, 5'd0),           5'd0,  64'h6,        1'b1);
    send(0, enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd6),     5'd6,  64'h0,        1'b1);
    send(0, enc_i(12'h0F0, 5'd1, 3'b100, 5'd7),         5'd7,  64'hFFFFFF0F, 1'b1);
    send(0, enc_i(12'h7FF, 5'd5, 3'b111, 5'd8),         5'd8,  64'h7FF,      1'b1);
    send(0, enc_i(12'd31, 5'd1, 3'b001, 5'd10),         5'd10, 64'h80000000, 1'b1);
    send(0, enc_i(12'h000, 5'd1, 3'b010, 5'd11),        5'd11, 64'h1,        1'b1);
    send(0, enc_r(7'h00, 5'd1, 5'd0, 3'b011, 5'd12),    5'd12, 64'h1,        1'b1);
    send(0, enc_r(7'h00, 5'd5, 5'd1, 3'b100, 5'd13),    5'd13, 64'hF0000000, 1'b1);
    send(0, enc_r(7'h20, 5'd5, 5'd10, 3'b101, 5'd16),   5'd16, 64'hFFFFFFFF, 1'b1);
    send(0, enc_r(7'h00, 5'd5, 5'd10, 3'b101, 5'd17),   5'd17, 64'h1,        1'b1);
    send(0, enc_r(7'h20, 5'd1, 5'd0, 3'b000, 5'd18),    5'd18, 64'h1,        1'b1);
    send(0, enc_r(7'h00, 5'd5, 5'd18, 3'b001, 5'd20),   5'd20, 64'h80000000, 1'b1);
    send(0, enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd19),    5'd19, 64'hFFFFFFFE, 1'b1);
    send(0, enc_r(7'h00, 5'd13, 5'd8, 3'b110, 5'd21),   5'd21, 64'hF00007FF, 1'b1);
    send(0, enc_r(7'h00, 5'd5, 5'd2, 3'b111, 5'd22),    5'd22, 64'h0FFFFFFF, 1'b1);
    send(0, enc_i(12'hFFE, 5'd0, 3'b110, 5'd9),         5'd9,  64'hFFFFFFFE, 1'b1);
    send(0, enc_r(7'h00, 5'd1, 5'd0, 3'b010, 5'd23),    5'd23, 64'h0,        1'b1);
    drain(0);
    tests++;
    if (rc_a - base !== 32'd22) begin fails++; $display("[TB] FAIL alu_count: got %0d, required 22", rc_a - base); end
  endtask

  task automatic test_xlen64();
    send(2, enc_i(12'd1, 5'd0, 3'b000, 5'd1),    5'd1, 64'h0000_0000_0000_0001, 1'b1);
    send(2, enc_i(12'd40, 5'd1, 3'b001, 5'd2),   5'd2, 64'h0000_0100_0000_0000, 1'b1);
    send(2, enc_i(12'hFFF, 5'd0, 3'b000, 5'd3),  5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    send(2, enc_i(12'h004, 5'd3, 3'b101, 5'd4),  5'd4, 64'h0FFF_FFFF_FFFF_FFFF, 1'b1);
    send(2, enc_i(12'h428, 5'd2, 3'b101, 5'd5),  5'd5, 64'h0000_0000_0000_0001, 1'b1);
    send(2, enc_i(12'd63, 5'd3, 3'b001, 5'd6),   5'd6, 64'h8000_0000_0000_0000, 1'b1);
    drain(2);
    tests++;
    if (rc_c !== 2'd2) begin fails++; $display("[TB] FAIL x64_count_wrap: got %0d, required 2", rc_c); end
  endtask

  task automatic test_illegal();
    logic [31:0] base;
    logic [7:0]  pv;
    base = rc_a;
    fork
      begin
        send(0, enc_i(12'd3, 5'd0, 3'b000, 5'd1), 5'd1, 64'd3, 1'b1);
        send(0, 32'h0000007F, 5'd0, 64'd0, 1'b0);
        send(0, enc_i(12'd4, 5'd1, 3'b000, 5'd2), 5'd2, 64'd7, 1'b1);
      end
      begin
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          pv[k] = ov[0];
        end
      end
    join
    @(posedge clk);
    #1;
    tests++;
    if (pv !== 8'b0010_1000) begin fails++; $display("[TB] FAIL ill_valid_pattern: got %b, required 00101000", pv); end
    drain(0);
    tests++;
    if (rc_a - base !== 32'd2) begin fails++; $display("[TB] FAIL ill_count: got %0d, required 2", rc_a - base); end
    send(0, enc_r(7'h01, 5'd1, 5'd1, 3'b000, 5'd9), 5'd0, 64'd0, 1'b0);
    send(0, enc_r(7'h00, 5'd1, 5'd2, 3'b000, 5'd10), 5'd10, 64'd10, 1'b1);
    drain(0);
    tests++;
    if (rc_a - base !== 32'd3) begin fails++; $display("[TB] FAIL ill_f7_count: got %0d, required 3", rc_a - base); end
  endtask

  task automatic test_reset_midstream();
    ordy[0] = 1'b0;
    send(0, enc_i(12'd9, 5'd0, 3'b000, 5'd1), 5'd1, 64'd9, 1'b1);
    send(0, enc_i(12'd9, 5'd0, 3'b000, 5'd2), 5'd2, 64'd9, 1'b1);
    send(0, enc_i(12'd9, 5'd0, 3'b000, 5'd3), 5'd3, 64'd9, 1'b1);
    #1;
    tests++;
    if (ov[0] !== 1'b1) begin fails++; $display("[TB] FAIL mid_full: got out_valid=%b, required 1", ov[0]); end
    rst = 1'b1;
    #1;
    tests += 4;
    if (ov[0] !== 1'b0) begin fails++; $display("[TB] FAIL mid_out_valid: got %b, required 0", ov[0]); end
    if (rc_a !== 32'd0) begin fails++; $display("[TB] FAIL mid_count: got %0d, required 0", rc_a); end
    if (od_a !== 32'd0) begin fails++; $display("[TB] FAIL mid_out_data: got %h, required 0", od_a); end
    if (ord[0] !== 5'd0) begin fails++; $display("[TB] FAIL mid_out_rd: got %0d, required 0", ord[0]); end
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ordy[0] = 1'b1;
    send(0, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd4), 5'd4, 64'd0, 1'b1);
    send(0, enc_i(12'd0, 5'd3, 3'b000, 5'd5),       5'd5, 64'd0, 1'b1);
    send(0, enc_r(7'h00, 5'd10, 5'd7, 3'b110, 5'd6), 5'd6, 64'd0, 1'b1);
    drain(0);
    tests++;
    if (rc_a !== 32'd3) begin fails++; $display("[TB] FAIL mid_post_count: got %0d, required 3", rc_a); end
  endtask

  initial begin
    test_reset();
    test_forward_chain();
    test_interlock_chain();
    test_back_pressure();
    test_alu_corners();
    test_xlen64();
    test_illegal();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1);
  end

endmodule
